// File: rtl/apb_bridge_ctrl.sv
// APB master controller: valid/ready requests in, APB SETUP/ACCESS transfers out, with slave decode and wait-state timeout.
// Define APB_BRIDGE_CTRL_PIPE_EN to add a one-entry request buffer for back-to-back transfers.
module apb_bridge_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [NSLV-1:0]   Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DERR   = 2'd3
  } state_t;

  state_t            state_q, state_d;

  logic [NSLV-1:0]   pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic              accept;
  logic              launch;
  logic              src_valid;
  logic              src_write;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic [SEL_W-1:0]  src_idx;
  logic [NSLV-1:0]   sel_onehot;
  logic              decode_ok;
  logic              timeout_hit;

  assign accept = req_valid & req_ready;

`ifdef APB_BRIDGE_CTRL_PIPE_EN
  logic              buf_valid_q, buf_valid_d;
  logic              buf_write_q;
  logic [ADDR_W-1:0] buf_addr_q;
  logic [DATA_W-1:0] buf_wdata_q;
  logic              buf_store;

  // The buffered request always has priority; the buffer only fills when nothing is launched that cycle.
  assign src_valid   = buf_valid_q | accept;
  assign src_write   = buf_valid_q ? buf_write_q : req_write;
  assign src_addr    = buf_valid_q ? buf_addr_q  : req_addr;
  assign src_wdata   = buf_valid_q ? buf_wdata_q : req_wdata;
  assign buf_store   = accept & ~launch;
  assign buf_valid_d = buf_store | (buf_valid_q & ~launch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_write_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      if (buf_store) begin
        buf_write_q <= req_write;
        buf_addr_q  <= req_addr;
        buf_wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready = rst & ~buf_valid_q & (state_q != S_DERR);
`else
  assign src_valid = accept;
  assign src_write = req_write;
  assign src_addr  = req_addr;
  assign src_wdata = req_wdata;
  assign req_ready = rst & (state_q == S_IDLE);
`endif

  assign src_idx = src_addr[ADDR_W-1 -: SEL_W];

  // Indices at or above NSLV match no select bit, which doubles as the decode-error test.
  for (genvar gi = 0; gi < NSLV; gi++) begin : g_sel
    assign sel_onehot[gi] = (src_idx == SEL_W'(gi));
  end
  assign decode_ok = |sel_onehot;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (src_valid) launch = 1'b1;
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (Pready) begin
          state_d = S_IDLE;
`ifdef APB_BRIDGE_CTRL_PIPE_EN
          if (src_valid) launch = 1'b1;
`endif
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_DERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (launch) state_d = decode_ok ? S_SETUP : S_DERR;
  end

  always_comb begin
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        if (Pready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = Pslverr;
          rsp_rdata_d = (pwrite_q | Pslverr) ? '0 : Prdata;
          pselx_d     = '0;
          penable_d   = 1'b0;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          pselx_d     = '0;
          penable_d   = 1'b0;
        end else if (TIMEOUT != 0) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_DERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
      default: ;
    endcase
    if (launch) begin
      paddr_d    = src_addr;
      pwrite_d   = src_write;
      pwdata_d   = src_write ? src_wdata : '0;
      pselx_d    = sel_onehot;
      penable_d  = 1'b0;
      wait_cnt_d = '0;
    end
  end

  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
